// File: rtl/dot_product_accumulator.sv
// Signed dot-product MAC: accumulates vec_len operand beats, then holds a shifted, saturated result until out_ready.
// Result is registered 1 clock after the last beat; in_ready is low while a result is held. Define DPA_BIAS_EN for a first-beat bias.
module dot_product_accumulator #(
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 24,
   parameter int OUT_WIDTH = 16,
   parameter int LEN_WIDTH = 8,
   parameter int OUT_SHIFT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IN_WIDTH-1:0]  a_in,
   input  logic [IN_WIDTH-1:0]  w_in,
   input  logic [LEN_WIDTH-1:0] vec_len,
   input  logic [OUT_WIDTH-1:0] bias_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sat,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                      state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [LEN_WIDTH-1:0]        count_q, count_d;
   logic [LEN_WIDTH-1:0]        len_q, len_d;
   logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
   logic                        out_sat_q, out_sat_d;

   logic signed [2*IN_WIDTH-1:0]    prod;
   logic signed [ACC_WIDTH-1:0]     prod_ext;
   logic signed [ACC_WIDTH-1:0]     first_val;
   logic signed [ACC_WIDTH-1:0]     acc_sum;
   logic signed [ACC_WIDTH-1:0]     acc_shift;
   logic [ACC_WIDTH-OUT_WIDTH:0]    acc_hi;
   logic                            no_clip;
   logic                            last_beat;

   localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   assign prod     = (2*IN_WIDTH)'($signed(a_in)) * (2*IN_WIDTH)'($signed(w_in));
   assign prod_ext = ACC_WIDTH'(prod);

`ifdef DPA_BIAS_EN
   assign first_val = prod_ext + ACC_WIDTH'($signed(bias_in));
`else
   logic unused_bias;
   assign unused_bias = ^bias_in;
   assign first_val   = prod_ext;
`endif

   assign acc_sum   = (state_q == IDLE) ? first_val : (acc_q + prod_ext);
   assign acc_shift = acc_sum >>> OUT_SHIFT;
   // In range iff every bit above the output sign bit matches it.
   assign acc_hi    = acc_shift[ACC_WIDTH-1:OUT_WIDTH-1];
   assign no_clip   = (&acc_hi) | ~(|acc_hi);

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      count_d    = count_q;
      len_d      = len_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;
      last_beat  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d     = acc_sum;
               count_d   = LEN_WIDTH'(1);
               len_d     = vec_len;
               last_beat = (vec_len <= LEN_WIDTH'(1));
               state_d   = last_beat ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_d     = acc_sum;
               count_d   = count_q + LEN_WIDTH'(1);
               last_beat = (count_d == len_q);
               if (last_beat) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (last_beat) begin
         out_data_d = no_clip ? acc_shift[OUT_WIDTH-1:0]
                              : (acc_shift[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX);
         out_sat_d  = ~no_clip;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         count_q    <= '0;
         len_q      <= '0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         len_q      <= len_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
      end
   end

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator; expected results hand-computed from the operand pairs.
module tb_dot_product_accumulator;
   localparam int IW = 8;
   localparam int AW = 24;
   localparam int OW = 16;
   localparam int LW = 8;
`ifdef DPA_BIAS_EN
   localparam int BIAS_ON = 1;
`else
   localparam int BIAS_ON = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [IW-1:0] a_in, w_in;
   logic [LW-1:0] vec_len;
   logic [OW-1:0] bias_in;
   logic          in_valid, in_ready;
   logic [OW-1:0] out_data;
   logic          out_valid, out_ready, out_sat, busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dot_product_accumulator #(
      .IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .LEN_WIDTH(LW), .OUT_SHIFT(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .w_in(w_in), .vec_len(vec_len),
      .bias_in(bias_in), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sat(out_sat), .busy(busy)
   );

   // Offer one beat for exactly one edge; returns 1 time unit after that edge.
   task automatic beat(input int a, input int w, input int len, input int b);
      a_in = IW'(a); w_in = IW'(w); vec_len = LW'(len); bias_in = OW'(b);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a_in = '0; w_in = '0; vec_len = '0; bias_in = '0;
      #3;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data got=%h want=0000", out_data); end
      total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL rst_out_sat got=%b want=0", out_sat); end
      #9 rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_basic();
      logic [OW-1:0] exp;
      exp = OW'(1*2 + 3*4 + (-5)*6 + 7*(-8) + 10*BIAS_ON);
      beat(1, 2, 4, 10);
      beat(3, 4, 9, 99);
      beat(-5, 6, 1, 77);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
      beat(7, -8, 0, 0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
      total++; if (out_data !== exp) begin bad++; $display("FAIL basic_data got=%h want=%h", out_data, exp); end
      total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b want=0", out_sat); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready got=%b want=0", in_ready); end
      take();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy); end
   endtask

   task automatic test_saturate();
      repeat (3) beat(127, 127, 3, 0);
      total++; if (out_data !== 16'h7FFF) begin bad++; $display("FAIL sat_pos_data got=%h want=7fff", out_data); end
      total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_pos_flag got=%b want=1", out_sat); end
      take();
      repeat (3) beat(-128, 127, 3, 0);
      total++; if (out_data !== 16'h8000) begin bad++; $display("FAIL sat_neg_data got=%h want=8000", out_data); end
      total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_neg_flag got=%b want=1", out_sat); end
      take();
      // 2*16129 + 508 + 1 = 32767: exactly at the top, not clipped
      beat(127, 127, 4, 0); beat(127, 127, 0, 0); beat(127, 4, 0, 0); beat(1, 1, 0, 0);
      total++; if (out_data !== 16'h7FFF) begin bad++; $display("FAIL edge_pos_data got=%h want=7fff", out_data); end
      total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL edge_pos_flag got=%b want=0", out_sat); end
      take();
      // 2*(-16256) - 256 = -32768: exactly at the bottom, not clipped
      beat(-128, 127, 3, 0); beat(-128, 127, 0, 0); beat(-128, 2, 0, 0);
      total++; if (out_data !== 16'h8000) begin bad++; $display("FAIL edge_neg_data got=%h want=8000", out_data); end
      total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL edge_neg_flag got=%b want=0", out_sat); end
      take();
   endtask

   task automatic test_len_one();
      for (int k = 0; k < 2; k++) begin
         beat(-3, 3, 1 - k, 0);
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL len%0d_valid got=%b want=1", 1 - k, out_valid); end
         total++; if (out_data !== 16'hFFF7) begin bad++; $display("FAIL len%0d_data got=%h want=fff7", 1 - k, out_data); end
         total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL len%0d_sat got=%b want=0", 1 - k, out_sat); end
         take();
      end
   endtask

   task automatic test_gaps_hold();
      logic [OW-1:0] exp;
      exp = OW'(10*10 + (-2)*5 + 3*3 + 0*7);
      out_ready = 1'b1;
      idle(1);
      beat(10, 10, 4, 0);
      idle(2);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b want=1", busy); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_valid got=%b want=0", out_valid); end
      beat(-2, 5, 0, 0);
      idle(1);
      beat(3, 3, 0, 0);
      idle(3);
      out_ready = 1'b0;
      beat(0, 7, 0, 0);
      a_in = 8'd100; w_in = 8'd100; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%b want=1", c, out_valid); end
         total++; if (out_data !== exp) begin bad++; $display("FAIL hold_data c=%0d got=%h want=%h", c, out_data, exp); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c=%0d got=%b want=0", c, in_ready); end
         idle(1);
      end
      in_valid = 1'b0;
      take();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_drop got=%b want=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      logic [OW-1:0] exp;
      int            pulses;
      exp = OW'(2*2 + 2*2 + 5*BIAS_ON);
      beat(5, 5, 4, 3);
      beat(5, 5, 0, 0);
      rst_n = 1'b0;
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
      rst_n = 1'b1;
      idle(3);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_stale got=%b want=0", out_valid); end
      beat(2, 2, 2, 5);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fresh_early got=%b want=0", out_valid); end
      beat(2, 2, 0, 0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fresh_valid got=%b want=1", out_valid); end
      total++; if (out_data !== exp) begin bad++; $display("FAIL fresh_data got=%h want=%h", out_data, exp); end
      take();
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         if (out_valid) pulses++;
         idle(1);
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL fresh_extra_pulses got=%0d want=0", pulses); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_len_one();
      test_gaps_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
